// File: rtl/mc14500_seq.sv
// rtl/mc14500_seq.sv - MC14500B-style 1-bit controller with program store, mapped I/O and FETCH/EXEC sequencer
// Optional return stack for JMP/RTN enabled by defining MC14500_STACK_EN.
module mc14500_seq #(
    parameter int ADDR        = 8,
    parameter int CODE        = 4,
    parameter int WORD        = ADDR + CODE,
    parameter int IO_CH       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             program_write,
    input  logic [ADDR-1:0]  program_addr,
    input  logic [WORD-1:0]  program_cmd,
    input  logic [IO_CH-1:0] io_in,
    output logic [IO_CH-1:0] io_out,
    output logic [CODE-1:0]  opcode,
    output logic [ADDR-1:0]  pc,
    output logic             rr,
    output logic             flag_o,
    output logic             flag_f,
    output logic             jmp_flag,
    output logic             rtn_flag,
    output logic             running,
    output logic             stack_err
);
    localparam int DEPTH = 1 << ADDR;
    localparam logic [ADDR-1:0] A_RR = ADDR'(DEPTH - 1);
    localparam logic [ADDR-1:0] A_IO = ADDR'(DEPTH - 1 - IO_CH);

    localparam logic [CODE-1:0] OP_NOPO = CODE'(0);
    localparam logic [CODE-1:0] OP_LD   = CODE'(1);
    localparam logic [CODE-1:0] OP_LDC  = CODE'(2);
    localparam logic [CODE-1:0] OP_AND  = CODE'(3);
    localparam logic [CODE-1:0] OP_ANDC = CODE'(4);
    localparam logic [CODE-1:0] OP_OR   = CODE'(5);
    localparam logic [CODE-1:0] OP_ORC  = CODE'(6);
    localparam logic [CODE-1:0] OP_XNOR = CODE'(7);
    localparam logic [CODE-1:0] OP_STO  = CODE'(8);
    localparam logic [CODE-1:0] OP_STOC = CODE'(9);
    localparam logic [CODE-1:0] OP_IEN  = CODE'(10);
    localparam logic [CODE-1:0] OP_OEN  = CODE'(11);
    localparam logic [CODE-1:0] OP_JMP  = CODE'(12);
    localparam logic [CODE-1:0] OP_RTN  = CODE'(13);
    localparam logic [CODE-1:0] OP_SKZ  = CODE'(14);
    localparam logic [CODE-1:0] OP_NOPF = CODE'(15);

    if (IO_CH < 1 || IO_CH > DEPTH - 2 || STACK_DEPTH < 1) begin : g_bad_params
        $error("mc14500_seq: parameter out of range");
    end

    typedef enum logic [1:0] {
        S_STOP,
        S_FETCH,
        S_EXEC
    } state_t;

    state_t           r_state;
    state_t           w_state_next;

    logic [WORD-1:0]  r_prog [DEPTH];
    logic             r_ram  [DEPTH];
    logic [WORD-1:0]  r_ir;
    logic             r_d;
    logic [ADDR-1:0]  r_pc;
    logic             r_rr;
    logic             r_ien;
    logic             r_oen;
    logic             r_skip;
    logic [IO_CH-1:0] r_io;

    logic [WORD-1:0]  w_fetch_word;
    logic [ADDR-1:0]  w_fetch_addr;
    logic             w_fetch_d;
    logic [CODE-1:0]  w_op;
    logic [ADDR-1:0]  w_addr;
    logic             w_live;
    logic             w_start;
    logic             w_store;
    logic             w_wval;
    logic             w_ram_we;
    logic [ADDR-1:0]  w_pc_inc;
    logic [ADDR-1:0]  w_pc_next;
    logic             w_skip_next;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_STOP;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_STOP:  if (run) w_state_next = S_FETCH;
            S_FETCH: w_state_next = S_EXEC;
            S_EXEC:  w_state_next = run ? S_FETCH : S_STOP;
            default: w_state_next = S_STOP;
        endcase
    end

    // Operand is resolved through the data map at fetch time and gated by IEN.
    always_comb begin
        w_fetch_word = r_prog[r_pc];
        w_fetch_addr = w_fetch_word[ADDR-1:0];
        w_fetch_d    = r_ram[w_fetch_addr];
        if (w_fetch_addr == A_RR) begin
            w_fetch_d = r_rr;
        end
        for (int k = 0; k < IO_CH; k++) begin
            if (w_fetch_addr == A_IO + ADDR'(k)) begin
                w_fetch_d = io_in[k];
            end
        end
        w_fetch_d = w_fetch_d & r_ien;
    end

    assign w_op     = r_ir[WORD-1:ADDR];
    assign w_addr   = r_ir[ADDR-1:0];
    assign w_live   = (r_state == S_EXEC) && !r_skip;
    assign w_start  = (r_state == S_STOP) && run;
    assign w_store  = w_live && r_oen && ((w_op == OP_STO) || (w_op == OP_STOC));
    assign w_wval   = (w_op == OP_STO) ? r_rr : ~r_rr;
    assign w_ram_we = rst && w_store && (w_addr < A_IO);
    assign w_pc_inc = r_pc + ADDR'(1);

`ifdef MC14500_STACK_EN
    localparam int SPW = $clog2(STACK_DEPTH + 1);

    logic [ADDR-1:0]  r_stack [STACK_DEPTH];
    logic [SPW-1:0]   r_sp;
    logic             r_err;
    logic [ADDR-1:0]  w_top;
    logic             w_full;
    logic             w_empty;

    always_comb begin
        w_top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (r_sp == SPW'(i + 1)) w_top = r_stack[i];
        end
    end

    assign w_full  = (r_sp == SPW'(STACK_DEPTH));
    assign w_empty = (r_sp == '0);

    // A push onto a full stack is dropped but the jump itself still happens.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sp  <= '0;
            r_err <= 1'b0;
        end else if (w_start) begin
            r_sp <= '0;
        end else if (w_live && (w_op == OP_JMP)) begin
            if (w_full) begin
                r_err <= 1'b1;
            end else begin
                for (int i = 0; i < STACK_DEPTH; i++) begin
                    if (r_sp == SPW'(i)) r_stack[i] <= w_pc_inc;
                end
                r_sp <= r_sp + SPW'(1);
            end
        end else if (w_live && (w_op == OP_RTN)) begin
            if (w_empty) begin
                r_err <= 1'b1;
            end else begin
                r_sp <= r_sp - SPW'(1);
            end
        end
    end

    assign stack_err = r_err;
`else
    assign stack_err = 1'b0;
`endif

    always_comb begin
        w_pc_next   = w_pc_inc;
        w_skip_next = 1'b0;
        if (w_live) begin
            case (w_op)
                OP_SKZ: w_skip_next = ~r_rr;
                OP_JMP: w_pc_next = w_addr;
                OP_RTN: begin
`ifdef MC14500_STACK_EN
                    if (w_empty) begin
                        w_skip_next = 1'b1;
                    end else begin
                        w_pc_next = w_top;
                    end
`else
                    w_skip_next = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_pc   <= '0;
            r_rr   <= 1'b0;
            r_ien  <= 1'b1;
            r_oen  <= 1'b1;
            r_skip <= 1'b0;
            r_io   <= '0;
            r_ir   <= '0;
            r_d    <= 1'b0;
        end else if (w_start) begin
            r_pc   <= '0;
            r_rr   <= 1'b0;
            r_ien  <= 1'b1;
            r_oen  <= 1'b1;
            r_skip <= 1'b0;
        end else if (r_state == S_FETCH) begin
            r_ir <= w_fetch_word;
            r_d  <= w_fetch_d;
        end else if (r_state == S_EXEC) begin
            r_pc   <= w_pc_next;
            r_skip <= w_skip_next;
            if (w_live) begin
                case (w_op)
                    OP_LD:   r_rr  <= r_d;
                    OP_LDC:  r_rr  <= ~r_d;
                    OP_AND:  r_rr  <= r_rr & r_d;
                    OP_ANDC: r_rr  <= r_rr & ~r_d;
                    OP_OR:   r_rr  <= r_rr | r_d;
                    OP_ORC:  r_rr  <= r_rr | ~r_d;
                    OP_XNOR: r_rr  <= ~(r_rr ^ r_d);
                    OP_IEN:  r_ien <= r_d;
                    OP_OEN:  r_oen <= r_d;
                    default: ;
                endcase
            end
            if (w_store) begin
                for (int k = 0; k < IO_CH; k++) begin
                    if (w_addr == A_IO + ADDR'(k)) r_io[k] <= w_wval;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_ram_we) r_ram[w_addr] <= w_wval;
    end

    // Program store survives reset; loading is only accepted while stopped.
    always_ff @(posedge clk) begin
        if (rst && program_write && (r_state == S_STOP)) begin
            r_prog[program_addr] <= program_cmd;
        end
    end

    assign io_out   = r_io;
    assign opcode   = w_op;
    assign pc       = r_pc;
    assign rr       = r_rr;
    assign flag_o   = w_live && (w_op == OP_NOPO);
    assign flag_f   = w_live && (w_op == OP_NOPF);
    assign jmp_flag = w_live && (w_op == OP_JMP);
    assign rtn_flag = w_live && (w_op == OP_RTN);
    assign running  = (r_state != S_STOP);

endmodule
